// File: rtl/fme_pkg.sv
// Shared constants and saturating add for the FME row/block SAD datapath.
// Pure combinational helpers; no state, no handshake.
// Default widths correspond to DATAWIDTH=8 and BLOCK_W=8.
package fme_pkg;

    localparam int NUM_CAND  = 12;
    localparam int NUM_SIDE  = 6;
    localparam int DATAWIDTH = 8;
    localparam int BLOCK_W   = 8;
    localparam int ROW_W     = DATAWIDTH + $clog2(BLOCK_W);
    localparam int SAD_W     = DATAWIDTH + 9;

    // Adds with one bit of headroom, then clamps to 2^w-1 so the result never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/sad_acc_lane.sv
// One block-SAD lane: saturating adder, running accumulator and held output register.
// Latency: output register updates on the clock edge of the commit strobe.
// Backpressure: none locally; the strobes are already qualified by the parent's handshake.
module sad_acc_lane #(
    parameter int SAD_W = 17,
    parameter int ROW_W = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             add,
    input  logic             commit,
    input  logic [ROW_W-1:0] row_sad,
    output logic [SAD_W-1:0] sad
);

    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] row_ext;
    logic [SAD_W-1:0] sum;

    always_comb begin
        row_ext = SAD_W'(row_sad);
        sum     = SAD_W'(fme_pkg::sat_add(32'(acc), 32'(row_sad), SAD_W));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            sad <= '0;
        end else begin
            if (load) begin
                acc <= row_ext;
            end else if (add) begin
                acc <= sum;
            end
            // A single-row block commits the raw row value, not acc+row.
            if (commit) begin
                sad <= load ? row_ext : sum;
            end
        end
    end

endmodule

// File: rtl/sad_row_accumulator.sv
// Sums 12 per-row candidate SADs over ROWS beats into a held bank of 12 block SADs.
// Latency: out_valid rises 1 cycle after the last row is accepted; 1 block per ROWS cycles.
// Backpressure: only the last row stalls while a bank is unconsumed; FME_PVSO_EN enables lanes 6-11.
module sad_row_accumulator #(
    parameter  int DATAWIDTH = 8,
    parameter  int BLOCK_W   = 8,
    parameter  int ROWS      = 8,
    localparam int ROW_W     = DATAWIDTH + $clog2(BLOCK_W),
    localparam int SAD_W     = DATAWIDTH + 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [12*ROW_W-1:0] row_sad,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [12*SAD_W-1:0] sad_bus,
    output logic [5:0]        row_cnt
);

    import fme_pkg::*;

`ifdef FME_PVSO_EN
    localparam int ACTIVE_LANES = NUM_CAND;
`else
    localparam int ACTIVE_LANES = NUM_SIDE;
`endif

    logic last_row;
    logic accept;
    logic lane_load;
    logic lane_add;
    logic lane_commit;

    always_comb begin
        last_row    = (row_cnt == 6'(ROWS - 1));
        in_ready    = !clear && (!last_row || !out_valid || out_ready);
        accept      = in_valid && in_ready;
        lane_load   = accept && (row_cnt == 6'd0);
        lane_add    = accept && (row_cnt != 6'd0);
        lane_commit = accept && last_row;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
        end else if (accept) begin
            row_cnt <= last_row ? 6'd0 : row_cnt + 6'd1;
        end
    end

    // A commit in the take cycle keeps out_valid high so blocks stream without a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else if (lane_commit) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < ACTIVE_LANES; k++) begin : g_lane
        sad_acc_lane #(
            .SAD_W (SAD_W),
            .ROW_W (ROW_W)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .load    (lane_load),
            .add     (lane_add),
            .commit  (lane_commit),
            .row_sad (row_sad[k*ROW_W +: ROW_W]),
            .sad     (sad_bus[k*SAD_W +: SAD_W])
        );
    end

`ifndef FME_PVSO_EN
    logic unused_right;
    assign unused_right = ^row_sad[NUM_CAND*ROW_W-1:NUM_SIDE*ROW_W];
    assign sad_bus[NUM_CAND*SAD_W-1:NUM_SIDE*SAD_W] = '0;
`endif

endmodule
